adc_sample_avg: RTL

ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

---
 rtl/adc_pkg.sv | 15 +
 rtl/avg_out_buf.sv | 52 +++++
 rtl/adc_sample_avg.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample averager.
//   ADC_W          : ADC sample / result width
//   LOG2_N_DEFAULT : default log2 of samples per averaging window
//   state_t        : averaging FSM states (IDLE, ACCUM)
package adc_pkg;

  localparam int unsigned ADC_W          = 16;
  localparam int unsigned LOG2_N_DEFAULT = 4;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

endpackage

// File: rtl/avg_out_buf.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
// A new result is loaded when the buffer is empty or is being accepted in the
// same cycle; otherwise the new result is dropped and overrun is set.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   load             : a completed window result is presented on data_in
//   data_in/data_out : result to capture / held result
//   valid, ready     : data_out holds an unaccepted result / downstream accepts
//   overrun          : sticky, a completed result was dropped
//   clear_ovr        : one-cycle pulse clearing overrun (a same-cycle drop wins)
module avg_out_buf #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         valid,
  input  logic         ready,
  output logic         overrun,
  input  logic         clear_ovr
);

  logic accept;
  logic drop;

  assign accept = valid && ready;
  assign drop   = load && valid && !ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load && (!valid || ready)) begin
        data_out <= data_in;
        valid    <= 1'b1;
      end else if (accept) begin
        valid    <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_sample_avg.sv
// ADC sample averager: accumulates 2^LOG2_N valid samples per window and
// emits the truncated mean through a valid/ready output buffer.
// Optional feature macro: ADC_AVG_PEAK_EN adds peak_out, the window maximum,
// which travels through the output buffer together with avg_out.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   enable                 : run averaging (low holds in IDLE, discarding partial window)
//   sample_in/sample_valid : unsigned ADC word and its one-cycle strobe
//   avg_out/avg_valid      : averaged result and its valid flag
//   avg_ready              : downstream accepts avg_out when avg_valid && avg_ready
//   overrun                : sticky, a completed window was dropped
//   clear_ovr              : one-cycle pulse clearing overrun
//   peak_out               : window maximum (ADC_AVG_PEAK_EN only)
module adc_sample_avg
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_N = LOG2_N_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ADC_W-1:0] sample_in,
  input  logic             sample_valid,
  output logic [ADC_W-1:0] avg_out,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             overrun,
  input  logic             clear_ovr
`ifdef ADC_AVG_PEAK_EN
  ,
  output logic [ADC_W-1:0] peak_out
`endif
);

  localparam int unsigned ACC_W = ADC_W + LOG2_N;
  localparam int unsigned N     = 1 << LOG2_N;
  // A one-bit counter keeps LOG2_N=0 legal; it then stays at 0.
  localparam int unsigned CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

`ifdef ADC_AVG_PEAK_EN
  localparam int unsigned BUF_W = 2 * ADC_W;
`else
  localparam int unsigned BUF_W = ADC_W;
`endif

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic             take;
  logic             last;
  logic             win_done;
  logic [ADC_W-1:0] win_avg;
  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_out;

  // The closing sample is folded in combinationally so the accumulator can
  // restart at zero on the same edge and the next window loses no sample.
  assign sum      = acc + ACC_W'(sample_in);
  assign take     = (state == ACCUM) && enable && sample_valid;
  assign last     = (cnt == LAST);
  assign win_done = take && last;
  assign win_avg  = sum[LOG2_N +: ADC_W];

`ifdef ADC_AVG_PEAK_EN
  logic [ADC_W-1:0] peak_run;
  logic [ADC_W-1:0] win_peak;

  assign win_peak = (sample_in > peak_run) ? sample_in : peak_run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_run <= '0;
    end else if ((state == ACCUM) && !enable) begin
      peak_run <= '0;
    end else if (take) begin
      peak_run <= last ? '0 : win_peak;
    end
  end

  assign buf_in   = {win_peak, win_avg};
  assign peak_out = buf_out[BUF_W-1 -: ADC_W];
`else
  assign buf_in   = win_avg;
`endif

  assign avg_out = buf_out[ADC_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (!enable) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (sample_valid) begin
            if (last) begin
              acc <= '0;
              cnt <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  avg_out_buf #(
    .W(BUF_W)
  ) u_avg_out_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (win_done),
    .data_in  (buf_in),
    .data_out (buf_out),
    .valid    (avg_valid),
    .ready    (avg_ready),
    .overrun  (overrun),
    .clear_ovr(clear_ovr)
  );

endmodule
